// File: rtl/keyboard_pkg.sv
// Shared mode constants, arbiter state type and mode_select decode for the
// speaker mode arbiter.
package keyboard_pkg;

  localparam logic [1:0] MODE_FREE  = 2'd0;
  localparam logic [1:0] MODE_AUTO  = 2'd1;
  localparam logic [1:0] MODE_LEARN = 2'd2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DEFER = 2'd1,
    MUTE  = 2'd2
  } arb_state_t;

  // Unused switch codes fall back to free piano.
  function automatic logic [1:0] decode_mode(input logic [2:0] sel);
    case (sel)
      3'd1:    decode_mode = MODE_AUTO;
      3'd2:    decode_mode = MODE_LEARN;
      default: decode_mode = MODE_FREE;
    endcase
  endfunction

endpackage

// File: rtl/mode_debouncer.sv
// Accepts a decoded mode only after it has held unchanged for STABLE_CYCLES
// cycles; the counter saturates at its terminal count.
module mode_debouncer
  import keyboard_pkg::*;
#(
  parameter int STABLE_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode_in,
  output logic [1:0] mode_out
);

  localparam int            CW     = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(STABLE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    prev_q;
  logic [1:0]    out_q, out_d;

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (mode_in != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TC) begin
      out_d = mode_in;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      prev_q <= MODE_FREE;
      out_q  <= MODE_FREE;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= mode_in;
      out_q  <= out_d;
    end
  end

  assign mode_out = out_q;

endmodule

// File: rtl/speaker_mode_arbiter.sv
// Owns speaker/LED outputs for the free, auto and learn sources and sequences
// mode changes as mute -> restart -> grant. Option: ARB_DEFER_EN adds src_busy and DEFER.
module speaker_mode_arbiter
  import keyboard_pkg::*;
#(
  parameter int STABLE_CYCLES = 2_000_000,
`ifdef ARB_DEFER_EN
  parameter int DEFER_MAX     = 50_000_000,
`endif
  parameter int MUTE_CYCLES   = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode_select,
  input  logic [2:0] src_speaker,
  input  logic [6:0] led_free,
  input  logic [6:0] led_auto,
  input  logic [6:0] led_learn,
`ifdef ARB_DEFER_EN
  input  logic [2:0] src_busy,
`endif
  output logic       speaker,
  output logic [6:0] led,
  output logic [1:0] active_mode,
  output logic [2:0] sub_reset,
  output logic       switching
);

  localparam int            MW      = $clog2(MUTE_CYCLES + 1);
  localparam logic [MW-1:0] MUTE_TC = MW'(MUTE_CYCLES - 1);

  logic [1:0]    req_mode;
  arb_state_t    state_q, state_d;
  logic [1:0]    active_q, active_d;
  logic [1:0]    target_q, target_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic          speaker_q, speaker_d;
  logic [6:0]    led_q, led_d;
  logic          spk_mux;
  logic [6:0]    led_mux;

  mode_debouncer #(.STABLE_CYCLES(STABLE_CYCLES)) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .mode_in  (decode_mode(mode_select)),
    .mode_out (req_mode)
  );

  always_comb begin
    spk_mux = src_speaker[0];
    led_mux = led_free;
    case (active_q)
      MODE_AUTO: begin
        spk_mux = src_speaker[1];
        led_mux = led_auto;
      end
      MODE_LEARN: begin
        spk_mux = src_speaker[2];
        led_mux = led_learn;
      end
      default: ;
    endcase
  end

`ifdef ARB_DEFER_EN
  localparam int            DW       = $clog2(DEFER_MAX + 1);
  localparam logic [DW-1:0] DEFER_TC = DW'(DEFER_MAX - 1);

  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          busy_sel;

  always_comb begin
    busy_sel = src_busy[0];
    case (active_q)
      MODE_AUTO:  busy_sel = src_busy[1];
      MODE_LEARN: busy_sel = src_busy[2];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) dcnt_q <= '0;
    else       dcnt_q <= dcnt_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    target_d  = target_q;
    mcnt_d    = mcnt_q;
    speaker_d = spk_mux;
    led_d     = led_mux;
`ifdef ARB_DEFER_EN
    dcnt_d    = '0;
`endif
    case (state_q)
      RUN: begin
        if (req_mode != active_q) begin
          target_d = req_mode;
`ifdef ARB_DEFER_EN
          state_d  = DEFER;
`else
          state_d   = MUTE;
          speaker_d = 1'b0;
          led_d     = '0;
`endif
        end
      end
`ifdef ARB_DEFER_EN
      DEFER: begin
        if (req_mode == active_q) begin
          state_d = RUN;
        end else if (!busy_sel || dcnt_q == DEFER_TC) begin
          // Target freezes here, on MUTE entry, not on DEFER entry.
          target_d  = req_mode;
          state_d   = MUTE;
          speaker_d = 1'b0;
          led_d     = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
`endif
      MUTE: begin
        speaker_d = 1'b0;
        led_d     = '0;
        if (mcnt_q == MUTE_TC) begin
          active_d = target_q;
          mcnt_d   = '0;
          state_d  = RUN;
        end else begin
          mcnt_d = mcnt_q + MW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      active_q  <= MODE_FREE;
      target_q  <= MODE_FREE;
      mcnt_q    <= '0;
      speaker_q <= 1'b0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      target_q  <= target_d;
      mcnt_q    <= mcnt_d;
      speaker_q <= speaker_d;
      led_q     <= led_d;
    end
  end

  always_comb begin
    sub_reset = 3'b000;
    if (state_q == MUTE) begin
      case (target_q)
        MODE_AUTO:  sub_reset = 3'b010;
        MODE_LEARN: sub_reset = 3'b100;
        default:    sub_reset = 3'b001;
      endcase
    end
  end

  assign switching   = (state_q != RUN);
  assign speaker     = speaker_q;
  assign led         = led_q;
  assign active_mode = active_q;

endmodule

// File: tb/tb_speaker_mode_arbiter.sv
// Directed bench for speaker_mode_arbiter with STABLE_CYCLES=4, MUTE_CYCLES=8, DEFER_MAX=16.
module tb_speaker_mode_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] mode_select;
  logic [2:0] src_speaker;
  logic [6:0] led_free, led_auto, led_learn;
  logic [2:0] src_busy;
  logic       speaker;
  logic [6:0] led;
  logic [1:0] active_mode;
  logic [2:0] sub_reset;
  logic       switching;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  speaker_mode_arbiter #(
    .STABLE_CYCLES(4),
`ifdef ARB_DEFER_EN
    .DEFER_MAX(16),
`endif
    .MUTE_CYCLES(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode_select (mode_select),
    .src_speaker (src_speaker),
    .led_free    (led_free),
    .led_auto    (led_auto),
    .led_learn   (led_learn),
`ifdef ARB_DEFER_EN
    .src_busy    (src_busy),
`endif
    .speaker     (speaker),
    .led         (led),
    .active_mode (active_mode),
    .sub_reset   (sub_reset),
    .switching   (switching)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    mode_select = 3'd0;
    src_speaker = 3'b001;
    led_free = 7'h55;
    led_auto = 7'h2A;
    led_learn = 7'h0F;
    src_busy = 3'b000;
    tick();
    tick();
    check("rst_spk", 32'(speaker), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_active", 32'(active_mode), 32'd0);
    check("rst_subrst", 32'(sub_reset), 32'd0);
    check("rst_switching", 32'(switching), 32'd0);

    // free source passes through with one cycle of latency
    reset = 1'b0;
    tick();
    check("t1_spk_hi", 32'(speaker), 32'd1);
    check("t1_led", 32'(led), 32'h55);
    check("t1_active", 32'(active_mode), 32'd0);
    check("t1_switching", 32'(switching), 32'd0);
    src_speaker = 3'b000;
    tick();
    check("t1_spk_lo", 32'(speaker), 32'd0);

    // short glitch to LEARN and an unused code must not switch
    mode_select = 3'd2;
    repeat (3) tick();
    mode_select = 3'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t3_glitch_sw", 32'(switching), 32'd0);
      check("t3_glitch_sr", 32'(sub_reset), 32'd0);
    end
    mode_select = 3'd5;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t3_code5_sw", 32'(switching), 32'd0);
      check("t3_code5_act", 32'(active_mode), 32'd0);
    end

    // FREE -> AUTO
    src_speaker = 3'b011;
    mode_select = 3'd1;
    repeat (5) tick();
    check("t2_pre_sw", 32'(switching), 32'd0);
    check("t2_pre_spk", 32'(speaker), 32'd1);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("t2_mute_sw", 32'(switching), 32'd1);
      check("t2_mute_sr", 32'(sub_reset), 32'b010);
      check("t2_mute_spk", 32'(speaker), 32'd0);
      check("t2_mute_led", 32'(led), 32'd0);
      check("t2_mute_act", 32'(active_mode), 32'd0);
      tick();
    end
    check("t2_grant_act", 32'(active_mode), 32'd1);
    check("t2_grant_sw", 32'(switching), 32'd0);
    check("t2_grant_sr", 32'(sub_reset), 32'd0);
    check("t2_grant_spk0", 32'(speaker), 32'd0);
    tick();
    check("t2_auto_spk", 32'(speaker), 32'd1);
    check("t2_auto_led", 32'(led), 32'h2A);
    src_speaker = 3'b001;
    tick();
    check("t2_auto_spk_lo", 32'(speaker), 32'd0);

    // request change mid-MUTE: AUTO completes, then a separate switch to LEARN
    reset = 1'b1;
    mode_select = 3'd0;
    tick();
    reset = 1'b0;
    mode_select = 3'd1;
    repeat (6) tick();
    check("t4_m0_sr", 32'(sub_reset), 32'b010);
    mode_select = 3'd2;
    tick();
    for (int i = 1; i < 8; i++) begin
      check("t4_first_sr", 32'(sub_reset), 32'b010);
      check("t4_first_act", 32'(active_mode), 32'd0);
      tick();
    end
    check("t4_mid_act", 32'(active_mode), 32'd1);
    check("t4_mid_sw", 32'(switching), 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("t4_second_sr", 32'(sub_reset), 32'b100);
      check("t4_second_sw", 32'(switching), 32'd1);
      tick();
    end
    check("t4_final_act", 32'(active_mode), 32'd2);
    check("t4_final_sw", 32'(switching), 32'd0);

    // reset at MUTE cycle 3
    src_speaker = 3'b111;
    mode_select = 3'd1;
    repeat (6) tick();
    check("t5_m0_sr", 32'(sub_reset), 32'b010);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("t5_rst_act", 32'(active_mode), 32'd0);
    check("t5_rst_sw", 32'(switching), 32'd0);
    check("t5_rst_sr", 32'(sub_reset), 32'd0);
    check("t5_rst_spk", 32'(speaker), 32'd0);
    check("t5_rst_led", 32'(led), 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    check("t5_redeb_sw0", 32'(switching), 32'd0);
    tick();
    check("t5_redeb_sw1", 32'(switching), 32'd1);
    check("t5_redeb_sr", 32'(sub_reset), 32'b010);
    repeat (8) tick();
    check("t5_redeb_act", 32'(active_mode), 32'd1);

`ifdef ARB_DEFER_EN
    // busy source defers the switch until released
    reset = 1'b1;
    mode_select = 3'd0;
    src_busy = 3'b001;
    src_speaker = 3'b111;
    tick();
    reset = 1'b0;
    tick();
    mode_select = 3'd1;
    repeat (6) tick();
    for (int i = 0; i < 6; i++) begin
      check("t6_defer_sw", 32'(switching), 32'd1);
      check("t6_defer_sr", 32'(sub_reset), 32'd0);
      check("t6_defer_spk", 32'(speaker), 32'd1);
      check("t6_defer_act", 32'(active_mode), 32'd0);
      if (i == 5) src_busy = 3'b000;
      tick();
    end
    check("t6_rel_sr", 32'(sub_reset), 32'b010);
    check("t6_rel_spk", 32'(speaker), 32'd0);
    repeat (8) tick();
    check("t6_rel_act", 32'(active_mode), 32'd1);

    // busy held: DEFER times out after 16 cycles
    src_busy = 3'b010;
    mode_select = 3'd0;
    repeat (6) tick();
    for (int i = 0; i < 16; i++) begin
      check("t6_hold_sw", 32'(switching), 32'd1);
      check("t6_hold_sr", 32'(sub_reset), 32'd0);
      tick();
    end
    check("t6_timeout_sr", 32'(sub_reset), 32'b001);
    repeat (8) tick();
    check("t6_timeout_act", 32'(active_mode), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
